zq_cal_ctrl: RTL and testbench

ZQ calibration controller that finds the 7-bit `zq_config` drive code by successive approximation. It drives `zq_config` and `zq_cal_en` into the PHY backend comparator and reads back `comparator_out`, which is 1 when the trial code is too large. It resolves one bit per trial, MSB first. The final code stays applied to the PHY and is reported to the register/control side with a one-cycle `done` pulse.

---
 rtl/zq_cal_ctrl.sv | 128 ++++++++++++
 tb/tb_zq_cal_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zq_cal_ctrl.sv
// ZQ calibration controller: successive-approximation search for the PHY drive code,
// MSB first, with each trial code held SETTLE_CYCLES cycles before the comparator is sampled.
module zq_cal_ctrl #(
  parameter int WIDTH         = 7,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             comparator_out,
  output logic [WIDTH-1:0] zq_config,
  output logic             zq_cal_en,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] zq_code,
  output logic             range_err
);

  localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LOAD = CW'(SETTLE_CYCLES - 1);
  localparam logic [IW-1:0]    IDX_TOP  = IW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MSB_CODE = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE_CODE = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [IW-1:0]    idx, idx_nxt;
  logic [CW-1:0]    cnt, cnt_nxt;
  logic [WIDTH-1:0] acc, acc_nxt;
  logic [WIDTH-1:0] cfg_nxt, code_nxt;
  logic             en_nxt, rerr_nxt;
  logic [WIDTH-1:0] bit_mask;
  logic [WIDTH-1:0] decided;

  // acc holds only the bits already resolved; the bit under trial is added back if it passed
  assign bit_mask = ONE_CODE << idx;
  assign decided  = comparator_out ? acc : (acc | bit_mask);

  assign busy = (state == SETTLE);
  assign done = (state == DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      cnt       <= '0;
      acc       <= '0;
      zq_config <= '0;
      zq_code   <= '0;
      zq_cal_en <= 1'b0;
      range_err <= 1'b0;
    end else begin
      state     <= state_nxt;
      idx       <= idx_nxt;
      cnt       <= cnt_nxt;
      acc       <= acc_nxt;
      zq_config <= cfg_nxt;
      zq_code   <= code_nxt;
      zq_cal_en <= en_nxt;
      range_err <= rerr_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    cnt_nxt   = cnt;
    acc_nxt   = acc;
    cfg_nxt   = zq_config;
    code_nxt  = zq_code;
    en_nxt    = zq_cal_en;
    rerr_nxt  = range_err;

    case (state)
      IDLE: begin
        if (start && !abort) begin
          state_nxt = SETTLE;
          acc_nxt   = '0;
          idx_nxt   = IDX_TOP;
          cfg_nxt   = MSB_CODE;
          cnt_nxt   = CNT_LOAD;
          en_nxt    = 1'b1;
        end
      end

      SETTLE: begin
        if (abort) begin
          // Put the last good code back on the PHY rather than a half-searched trial
          state_nxt = IDLE;
          en_nxt    = 1'b0;
          cfg_nxt   = zq_code;
        end else if (cnt != '0) begin
          cnt_nxt = cnt - CW'(1);
        end else begin
          acc_nxt = decided;
          if (idx != '0) begin
            cfg_nxt = decided | (bit_mask >> 1);
            idx_nxt = idx - IW'(1);
            cnt_nxt = CNT_LOAD;
          end else begin
            state_nxt = DONE;
            cfg_nxt   = decided;
            code_nxt  = decided;
            rerr_nxt  = (decided == '0) || (decided == ALL_ONES);
            en_nxt    = 1'b0;
          end
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_zq_cal_ctrl.sv
// Self-checking bench for zq_cal_ctrl: a cycle-level model derived from the target result
// is compared every cycle, plus hand-computed trial sequences and results.
module tb_zq_cal_ctrl;

  localparam int W    = 7;
  localparam int S    = 4;
  localparam int MAXC = (1 << W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic rst, start, abort, comparator_out;
  logic [W-1:0] zq_config, zq_code;
  logic zq_cal_en, busy, done, range_err;

  logic start1, abort1, comparator_out1;
  logic [W-1:0] zq_config1, zq_code1;
  logic zq_cal_en1, busy1, done1, range_err1;

  int thr, thr1;
  logic noise;
  logic chk_en;

  int n_vec, n_err;

  int m_mode, m_t, m_res, m_cfg, m_code, m_rerr;

  zq_cal_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .comparator_out(comparator_out), .zq_config(zq_config), .zq_cal_en(zq_cal_en),
    .busy(busy), .done(done), .zq_code(zq_code), .range_err(range_err)
  );

  zq_cal_ctrl #(.WIDTH(W), .SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1),
    .comparator_out(comparator_out1), .zq_config(zq_config1), .zq_cal_en(zq_cal_en1),
    .busy(busy1), .done(done1), .zq_code(zq_code1), .range_err(range_err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic a, input logic r);
    start = s;
    abort = a;
    rst   = r;
    @(negedge clk);
  endtask

  // Trial k keeps the k already-resolved top bits of the result and sets the next bit
  function automatic int trial(input int res, input int k);
    int keep;
    keep = ~((1 << (W - k)) - 1);
    return (res & keep) | (1 << (W - 1 - k));
  endfunction

  // PHY comparator; with noise on, the answer is deliberately wrong on non-sampling cycles
  always @(negedge clk) begin
    if (noise && (m_t % S) != 0)
      comparator_out = !(int'(zq_config) > thr);
    else
      comparator_out = (int'(zq_config) > thr);
    comparator_out1 = (int'(zq_config1) > thr1);
  end

  always @(posedge clk) begin
    if (rst) begin
      m_mode = M_IDLE; m_t = 0; m_cfg = 0; m_code = 0; m_rerr = 0;
    end else begin
      case (m_mode)
        M_IDLE: if (start && !abort) begin
          m_mode = M_RUN;
          m_t    = 1;
          m_res  = (thr > MAXC) ? MAXC : thr;
          m_cfg  = trial(m_res, 0);
        end
        M_RUN: begin
          if (abort) begin
            m_mode = M_IDLE;
            m_cfg  = m_code;
          end else if (m_t == W * S) begin
            m_mode = M_DONE;
            m_cfg  = m_res;
            m_code = m_res;
            m_rerr = (m_res == 0 || m_res == MAXC) ? 1 : 0;
          end else begin
            m_t   = m_t + 1;
            m_cfg = trial(m_res, (m_t - 1) / S);
          end
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("model zq_config", int'(zq_config), m_cfg);
      checkOutput("model zq_code", int'(zq_code), m_code);
      checkOutput("model range_err", int'(range_err), m_rerr);
      checkOutput("model zq_cal_en", int'(zq_cal_en), (m_mode == M_RUN) ? 1 : 0);
      checkOutput("model busy", int'(busy), (m_mode == M_RUN) ? 1 : 0);
      checkOutput("model done", int'(done), (m_mode == M_DONE) ? 1 : 0);
    end
  end

  task automatic calibrate(input int t, input int exp_code, input int exp_rerr);
    thr = t;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (W * S) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("cal done pulse", int'(done), 1);
    checkOutput("cal zq_code", int'(zq_code), exp_code);
    checkOutput("cal zq_config", int'(zq_config), exp_code);
    checkOutput("cal range_err", int'(range_err), exp_rerr);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int exp42[7];
    int exp85[7];
    int done_cnt, first_done, last_done;
    exp42 = '{64, 32, 48, 40, 44, 42, 43};
    exp85 = '{64, 96, 80, 88, 84, 86, 85};
    n_vec = 0; n_err = 0; chk_en = 1'b0;
    rst = 1'b1; start = 1'b0; abort = 1'b0; noise = 1'b0; thr = 0;
    start1 = 1'b0; abort1 = 1'b0; thr1 = 0;
    m_mode = M_IDLE; m_t = 0; m_res = 0; m_cfg = 0; m_code = 0; m_rerr = 0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset zq_config", int'(zq_config), 0);
    checkOutput("reset zq_code", int'(zq_code), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset done", int'(done), 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] threshold 42 trial sequence");
    thr = 42;
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 1; c <= W * S; c++) begin
      if ((c - 1) % S == 0) checkOutput("trial code t42", int'(zq_config), exp42[(c - 1) / S]);
      applyStimulus(1'b0, 1'b0, 1'b0);
    end
    checkOutput("t42 done cycle 29", int'(done), 1);
    checkOutput("t42 zq_code", int'(zq_code), 42);
    checkOutput("t42 zq_config", int'(zq_config), 42);
    checkOutput("t42 range_err", int'(range_err), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("t42 done one cycle", int'(done), 0);

    $display("[TB] range limits");
    calibrate(0, 0, 1);
    calibrate(127, 127, 1);
    calibrate(200, 127, 1);
    calibrate(42, 42, 0);

    $display("[TB] abort mid-calibration");
    thr = 100;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (9) applyStimulus(1'b0, 1'b0, 1'b0);
    checkOutput("abort busy before", int'(busy), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("abort busy after", int'(busy), 0);
    checkOutput("abort zq_cal_en", int'(zq_cal_en), 0);
    checkOutput("abort zq_config restored", int'(zq_config), 42);
    checkOutput("abort zq_code kept", int'(zq_code), 42);
    done_cnt = 0;
    repeat (30) begin
      applyStimulus(1'b0, 1'b0, 1'b0);
      done_cnt += int'(done);
    end
    checkOutput("abort no done", done_cnt, 0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("start+abort stays idle", int'(busy), 0);
    checkOutput("abort in idle config", int'(zq_config), 42);

    $display("[TB] start held high");
    thr = 77; done_cnt = 0; first_done = -1; last_done = -1;
    for (int c = 1; c <= 95; c++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      if (done) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
    end
    checkOutput("held start done count", done_cnt, 3);
    checkOutput("held start first done", first_done, 29);
    checkOutput("held start last done", last_done, 89);
    checkOutput("held start zq_code", int'(zq_code), 77);
    repeat (40) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] reset mid-calibration");
    thr = 20;
    applyStimulus(1'b1, 1'b0, 1'b0);
    repeat (14) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("rst zq_config", int'(zq_config), 0);
    checkOutput("rst zq_code", int'(zq_code), 0);
    checkOutput("rst zq_cal_en", int'(zq_cal_en), 0);
    checkOutput("rst busy", int'(busy), 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    noise = 1'b1;
    calibrate(99, 99, 0);
    noise = 1'b0;
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);

    $display("[TB] single settle cycle, threshold 85");
    thr1 = 85;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    for (int c = 1; c <= W; c++) begin
      checkOutput("s1 trial code", int'(zq_config1), exp85[c - 1]);
      checkOutput("s1 no early done", int'(done1), 0);
      @(negedge clk);
    end
    checkOutput("s1 done cycle 8", int'(done1), 1);
    checkOutput("s1 zq_code", int'(zq_code1), 85);
    checkOutput("s1 zq_config", int'(zq_config1), 85);
    checkOutput("s1 zq_cal_en", int'(zq_cal_en1), 0);
    checkOutput("s1 range_err", int'(range_err1), 0);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
